comparator11_match: RTL and testbench



---
 rtl/comparator11_match.sv | 74 +++++++
 tb/tb_comparator11_match.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/comparator11_match.sv
// Masked equality comparator with registered/edge match outputs and unsigned ordering flags.
// Define COMPARATOR11_MATCH_COUNT_EN to build the saturating match_rise event counter.
module comparator11_match #(
  parameter int WIDTH     = 11,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     input_value,
  input  logic [WIDTH-1:0]     loaded_value,
  input  logic                 mask_load,
  input  logic [WIDTH-1:0]     mask_data,
  input  logic                 cnt_clr,
  output logic                 match,
  output logic                 match_q,
  output logic                 match_rise,
  output logic                 match_fall,
  output logic                 gt,
  output logic                 lt,
  output logic [CNT_WIDTH-1:0] match_count
);

  logic [WIDTH-1:0] r_mask;
  logic             r_match_q;
  logic             w_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= '1;
    end else if (mask_load) begin
      r_mask <= mask_data;
    end
  end

  assign w_match = (((input_value ^ loaded_value) & r_mask) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_match_q <= 1'b0;
    end else begin
      r_match_q <= w_match;
    end
  end

  assign match      = w_match;
  assign match_q    = r_match_q;
  assign match_rise = w_match & ~r_match_q;
  assign match_fall = ~w_match & r_match_q;
  // Ordering deliberately ignores the mask so boundary logic sees the true relation.
  assign gt         = (input_value > loaded_value);
  assign lt         = (input_value < loaded_value);

`ifdef COMPARATOR11_MATCH_COUNT_EN
  logic [CNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (cnt_clr) begin
      r_count <= '0;
    end else if (match_rise && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign match_count = r_count;
`else
  logic w_unused_cnt_clr;

  assign w_unused_cnt_clr = cnt_clr;
  assign match_count      = '0;
`endif

endmodule

// File: tb/tb_comparator11_match.sv
// Directed bench for comparator11_match; counter expectations follow COMPARATOR11_MATCH_COUNT_EN.
module tb_comparator11_match;
  localparam int W     = 11;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [W-1:0]     input_value;
  logic [W-1:0]     loaded_value;
  logic             mask_load;
  logic [W-1:0]     mask_data;
  logic             cnt_clr;
  logic             match, match_q, match_rise, match_fall, gt, lt;
  logic [CNT_W-1:0] match_count;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef COMPARATOR11_MATCH_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  comparator11_match #(.WIDTH(W), .CNT_WIDTH(CNT_W)) dut (
    .clk(clk), .rst(rst), .input_value(input_value), .loaded_value(loaded_value),
    .mask_load(mask_load), .mask_data(mask_data), .cnt_clr(cnt_clr),
    .match(match), .match_q(match_q), .match_rise(match_rise), .match_fall(match_fall),
    .gt(gt), .lt(lt), .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CNT_W-1:0] exp_cnt(input int n);
    int sat;
    sat = (n > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : n;
    return CNT_ON ? CNT_W'(sat) : '0;
  endfunction

  task automatic test_reset();
    rst = 1'b1; mask_load = 1'b0; mask_data = '0; cnt_clr = 1'b0;
    loaded_value = 11'h6DB; input_value = 11'h6DB;
    tick();
    n_tests++; if (match_q !== 1'b0) begin n_fail++; $display("FAIL reset_match_q got %b want 0", match_q); end
    n_tests++; if (match !== 1'b1) begin n_fail++; $display("FAIL reset_match got %b want 1", match); end
    n_tests++; if (match_rise !== 1'b1) begin n_fail++; $display("FAIL reset_rise got %b want 1", match_rise); end
    n_tests++; if (match_count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", match_count); end
    rst = 1'b0;
  endtask

  task automatic test_match();
    #1;
    n_tests++; if ({gt, lt} !== 2'b00) begin n_fail++; $display("FAIL eq_gt_lt got %b want 00", {gt, lt}); end
    tick();
    n_tests++; if (match_q !== 1'b1) begin n_fail++; $display("FAIL eq_match_q got %b want 1", match_q); end
    n_tests++; if ({match_rise, match_fall} !== 2'b00) begin n_fail++; $display("FAIL eq_edges got %b want 00", {match_rise, match_fall}); end
    n_tests++; if (match_count !== exp_cnt(1)) begin n_fail++; $display("FAIL eq_count got %0d want %0d", match_count, exp_cnt(1)); end
  endtask

  task automatic test_mismatch();
    input_value = 11'h555;
    #1;
    n_tests++; if (match !== 1'b0) begin n_fail++; $display("FAIL ne_match got %b want 0", match); end
    n_tests++; if ({gt, lt} !== 2'b01) begin n_fail++; $display("FAIL ne_gt_lt got %b want 01", {gt, lt}); end
    n_tests++; if ({match_rise, match_fall} !== 2'b01) begin n_fail++; $display("FAIL ne_edges got %b want 01", {match_rise, match_fall}); end
    tick();
    n_tests++; if ({match_q, match_fall} !== 2'b00) begin n_fail++; $display("FAIL ne_after got %b want 00", {match_q, match_fall}); end
  endtask

  task automatic test_mask();
    mask_load = 1'b1; mask_data = 11'h7F0;
    loaded_value = 11'h6D0; input_value = 11'h6DB;
    #1;
    n_tests++; if (match !== 1'b0) begin n_fail++; $display("FAIL mask_pre got %b want 0", match); end
    tick();
    mask_load = 1'b0;
    #1;
    n_tests++; if ({match, match_rise} !== 2'b11) begin n_fail++; $display("FAIL mask_match got %b want 11", {match, match_rise}); end
    n_tests++; if ({gt, lt} !== 2'b10) begin n_fail++; $display("FAIL mask_gt_lt got %b want 10", {gt, lt}); end
    tick();
    n_tests++; if (match_q !== 1'b1) begin n_fail++; $display("FAIL mask_match_q got %b want 1", match_q); end
    n_tests++; if (match_count !== exp_cnt(2)) begin n_fail++; $display("FAIL mask_count got %0d want %0d", match_count, exp_cnt(2)); end
  endtask

  task automatic test_mask_zero();
    logic [W-1:0] vals [3];
    vals[0] = 11'h000; vals[1] = 11'h555; vals[2] = 11'h7FF;
    mask_load = 1'b1; mask_data = 11'h000;
    tick();
    mask_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      input_value = vals[i];
      #1;
      n_tests++; if (match !== 1'b1) begin n_fail++; $display("FAIL zmask_match iv=%h got %b want 1", vals[i], match); end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_tests++; if (match_q !== 1'b0) begin n_fail++; $display("FAIL zmask_rst_q got %b want 0", match_q); end
    n_tests++; if (match !== 1'b0) begin n_fail++; $display("FAIL zmask_rst_full got %b want 0", match); end
    input_value = 11'h6D0;
    #1;
    n_tests++; if (match !== 1'b1) begin n_fail++; $display("FAIL zmask_rst_eq got %b want 1", match); end
  endtask

  task automatic test_count();
    loaded_value = 11'h6DB; input_value = 11'h555; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      input_value = 11'h6DB; tick();
      input_value = 11'h555; tick();
    end
    n_tests++; if (match_count !== exp_cnt(5)) begin n_fail++; $display("FAIL cnt5 got %0d want %0d", match_count, exp_cnt(5)); end
    input_value = 11'h6DB; cnt_clr = 1'b1;
    #1;
    n_tests++; if (match_rise !== 1'b1) begin n_fail++; $display("FAIL clr_rise got %b want 1", match_rise); end
    tick();
    cnt_clr = 1'b0;
    n_tests++; if (match_count !== '0) begin n_fail++; $display("FAIL cnt_clr got %0d want 0", match_count); end
    input_value = 11'h555; tick();
    for (int i = 0; i < (1 << CNT_W) + 4; i++) begin
      input_value = 11'h6DB; tick();
      input_value = 11'h555; tick();
      if (i == (1 << CNT_W) - 2) begin
        n_tests++; if (match_count !== exp_cnt(i + 1)) begin n_fail++; $display("FAIL cnt_top got %0d want %0d", match_count, exp_cnt(i + 1)); end
      end
    end
    n_tests++; if (match_count !== exp_cnt((1 << CNT_W) + 4)) begin n_fail++; $display("FAIL cnt_sat got %0d want %0d", match_count, exp_cnt((1 << CNT_W) + 4)); end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_mask();
    test_mask_zero();
    test_count();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
